// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: initiator side of the machine-mode CSR register file.
// Takes one decoded CSR/system instruction from EXU (valid/ready), sequences
// the CSR file's read/write/exception/return strobes, then returns rd data or
// a PC redirect over a valid/ready response.
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready, req_*         request handshake and payload
//   csr_re/csr_we/csr_num/csr_w*       CSR file read/write port
//   csr_rvalue, ex_entry               CSR file read data and trap vector
//   ex/ex_ret/epc/ecode                exception / mret strobes
//   rsp_valid/rsp_ready, rsp_*         response handshake and payload
module csr_access_ctrl #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned ECODE_ECALL  = 11,
    parameter int unsigned ECODE_EBREAK = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_pc,
    output logic            csr_re,
    output logic [11:0]     csr_num,
    input  logic [XLEN-1:0] csr_rvalue,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wmask,
    output logic [XLEN-1:0] csr_wvalue,
    output logic            ex,
    output logic            ex_ret,
    output logic [XLEN-1:0] epc,
    output logic [62:0]     ecode,
    input  logic [XLEN-1:0] ex_entry,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rd_data,
    output logic            rsp_redirect,
    output logic [XLEN-1:0] rsp_target,
    output logic            rsp_illegal
);

    localparam logic [3:0]  OP_CSRRW  = 4'd0;
    localparam logic [3:0]  OP_CSRRS  = 4'd1;
    localparam logic [3:0]  OP_CSRRC  = 4'd2;
    localparam logic [3:0]  OP_CSRRWI = 4'd3;
    localparam logic [3:0]  OP_CSRRSI = 4'd4;
    localparam logic [3:0]  OP_CSRRCI = 4'd5;
    localparam logic [3:0]  OP_ECALL  = 4'd8;
    localparam logic [3:0]  OP_EBREAK = 4'd9;
    localparam logic [3:0]  OP_MRET   = 4'd10;
    localparam logic [11:0] CSR_MEPC  = 12'h341;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_TRAP, S_ENTRY, S_RET, S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [3:0]      r_op;
    logic [11:0]     r_csr;
    logic [XLEN-1:0] r_rs1_val;
    logic [4:0]      r_rs1_idx;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd_data;
    logic [XLEN-1:0] r_target;
    logic            r_redirect;
    logic            r_illegal;

    logic            w_accept;
    logic            w_is_set;
    logic            w_is_clr;
    logic            w_suppress;
    logic            w_req_illegal;
    logic [XLEN-1:0] w_src;

    assign w_accept = req_valid && (r_state == S_IDLE);

    assign w_req_illegal = !((req_op <= OP_CSRRCI) || (req_op == OP_ECALL) ||
                             (req_op == OP_EBREAK) || (req_op == OP_MRET));

    // Operation class of the latched request
    assign w_is_set   = (r_op == OP_CSRRS) || (r_op == OP_CSRRSI);
    assign w_is_clr   = (r_op == OP_CSRRC) || (r_op == OP_CSRRCI);
    assign w_suppress = (w_is_set || w_is_clr) && (r_rs1_idx == 5'd0);
    assign w_src      = (r_op <= OP_CSRRC) ? r_rs1_val : XLEN'(r_rs1_idx);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op <= OP_CSRRCI)                          w_next = S_READ;
                    else if (req_op == OP_ECALL || req_op == OP_EBREAK) w_next = S_TRAP;
                    else if (req_op == OP_MRET)                       w_next = S_RET;
                    else                                              w_next = S_RESP;
                end
            end
            S_READ:  w_next = w_suppress ? S_RESP : S_WRITE;
            S_WRITE: w_next = S_RESP;
            S_TRAP:  w_next = S_ENTRY;
            S_ENTRY: w_next = S_RESP;
            S_RET:   w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // CSR-side and handshake outputs, decoded from state and latched request only
    always_comb begin
        req_ready  = 1'b0;
        csr_re     = 1'b0;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        ex         = 1'b0;
        ex_ret     = 1'b0;
        epc        = '0;
        ecode      = '0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_READ: begin
                csr_re  = 1'b1;
                csr_num = r_csr;
            end
            S_WRITE: begin
                csr_we  = 1'b1;
                csr_num = r_csr;
                if (w_is_set) begin
                    csr_wmask  = w_src;
                    csr_wvalue = '1;
                end else if (w_is_clr) begin
                    csr_wmask  = w_src;
                    csr_wvalue = '0;
                end else begin
                    csr_wmask  = '1;
                    csr_wvalue = w_src;
                end
            end
            S_TRAP: begin
                ex    = 1'b1;
                epc   = r_pc;
                ecode = (r_op == OP_EBREAK) ? 63'(ECODE_EBREAK) : 63'(ECODE_ECALL);
            end
            S_RET: begin
                ex_ret  = 1'b1;
                csr_re  = 1'b1;
                csr_num = CSR_MEPC;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch and response capture; response fields clear on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_csr      <= '0;
            r_rs1_val  <= '0;
            r_rs1_idx  <= '0;
            r_pc       <= '0;
            r_rd_data  <= '0;
            r_target   <= '0;
            r_redirect <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_op       <= req_op;
            r_csr      <= req_csr;
            r_rs1_val  <= req_rs1_val;
            r_rs1_idx  <= req_rs1_idx;
            r_pc       <= req_pc;
            r_rd_data  <= '0;
            r_target   <= '0;
            r_redirect <= 1'b0;
            r_illegal  <= w_req_illegal;
        end else begin
            case (r_state)
                S_READ:  r_rd_data <= csr_rvalue;
                S_ENTRY: begin
                    r_target   <= ex_entry;
                    r_redirect <= 1'b1;
                end
                S_RET: begin
                    r_target   <= csr_rvalue;
                    r_redirect <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rd_data  = r_rd_data;
    assign rsp_redirect = r_redirect;
    assign rsp_target   = r_target;
    assign rsp_illegal  = r_illegal;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a simple CSR file responds to the
// DUT's strobes, and a reference model of architectural CSR state predicts
// every response, strobe count and latency.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [11:0] req_csr = '0;
    logic [63:0] req_rs1_val = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [63:0] req_pc = '0;
    logic        csr_re;
    logic [11:0] csr_num;
    logic [63:0] csr_rvalue;
    logic        csr_we;
    logic [63:0] csr_wmask;
    logic [63:0] csr_wvalue;
    logic        ex;
    logic        ex_ret;
    logic [63:0] epc;
    logic [62:0] ecode;
    logic [63:0] ex_entry;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rd_data;
    logic        rsp_redirect;
    logic [63:0] rsp_target;
    logic        rsp_illegal;

    int total = 0;
    int bad   = 0;

    csr_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr(req_csr), .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx),
        .req_pc(req_pc),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .ex(ex), .ex_ret(ex_ret), .epc(epc), .ecode(ecode), .ex_entry(ex_entry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
        .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Simple CSR file driven by the DUT's strobes
    logic [63:0] slv_mem [4096];
    logic        slv_clr = 1'b1;

    always @(posedge clk) begin
        if (slv_clr) begin
            for (int i = 0; i < 4096; i++) slv_mem[i] <= '0;
        end else begin
            if (csr_we) slv_mem[csr_num] <= (slv_mem[csr_num] & ~csr_wmask) | (csr_wvalue & csr_wmask);
            if (ex) begin
                slv_mem[12'h341] <= epc;
                slv_mem[12'h342] <= {1'b0, ecode};
            end
        end
    end

    assign csr_rvalue = slv_mem[csr_num];
    assign ex_entry   = {slv_mem[12'h305][63:2], 2'b00};

    // Architectural reference state
    logic [63:0] ref_csr [logic [11:0]];

    function automatic logic [63:0] ref_get(input logic [11:0] a);
        return ref_csr.exists(a) ? ref_csr[a] : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, run it to completion with `hold` cycles of
    // response backpressure, and check everything predicted by the model.
    task automatic do_op(input logic [3:0] op, input logic [11:0] csr,
                         input logic [63:0] v, input logic [4:0] idx,
                         input logic [63:0] pc, input int hold,
                         output logic [63:0] o_mask, output logic [63:0] o_val);
        int          exp_lat, exp_re, exp_we, exp_ex, exp_ret;
        logic [63:0] exp_rd, exp_tgt, src, old_v, new_v;
        logic        exp_redir, exp_ill, is_csr, is_trap, is_mret, wr;
        int          lat, n_re, n_we, n_ex, n_ret, viol, hold_bad;
        logic [11:0] re_num;
        logic [63:0] ex_epc, ex_code;
        logic [63:0] s_rd, s_tgt;
        logic        s_redir, s_ill;

        is_csr  = (op <= 4'd5);
        is_trap = (op == 4'd8) || (op == 4'd9);
        is_mret = (op == 4'd10);
        old_v   = ref_get(csr);
        src     = (op <= 4'd2) ? v : {59'd0, idx};
        wr      = 1'b0;
        new_v   = old_v;
        exp_re = 0; exp_we = 0; exp_ex = 0; exp_ret = 0;
        exp_rd = '0; exp_tgt = '0; exp_redir = 1'b0; exp_ill = 1'b0; exp_lat = 1;
        if (is_csr) begin
            case (op)
                4'd0, 4'd3: begin wr = 1'b1;        new_v = src; end
                4'd1, 4'd4: begin wr = (idx != 0); new_v = old_v | src; end
                default:    begin wr = (idx != 0); new_v = old_v & ~src; end
            endcase
            if (!wr) new_v = old_v;
            exp_re = 1; exp_we = wr ? 1 : 0; exp_lat = wr ? 3 : 2; exp_rd = old_v;
        end else if (is_trap) begin
            exp_ex = 1; exp_lat = 3; exp_redir = 1'b1;
            exp_tgt = ref_get(12'h305) & ~64'd3;
        end else if (is_mret) begin
            exp_re = 1; exp_ret = 1; exp_lat = 2; exp_redir = 1'b1;
            exp_tgt = ref_get(12'h341);
        end else begin
            exp_ill = 1'b1;
        end

        req_op = op; req_csr = csr; req_rs1_val = v; req_rs1_idx = idx; req_pc = pc;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;

        lat = 0; n_re = 0; n_we = 0; n_ex = 0; n_ret = 0; viol = 0;
        re_num = '0; ex_epc = '0; ex_code = '0; o_mask = '0; o_val = '0;
        for (int k = 1; k <= 20; k++) begin
            if (csr_re) begin n_re++; re_num = csr_num; end
            if (csr_we) begin n_we++; o_mask = csr_wmask; o_val = csr_wvalue; end
            if (ex) begin n_ex++; ex_epc = epc; ex_code = {1'b0, ecode}; end
            if (ex_ret) n_ret++;
            if ((int'(csr_we) + int'(ex) + int'(ex_ret)) > 1) viol++;
            if (!csr_we && ((csr_wmask | csr_wvalue) != 0)) viol++;
            if (rsp_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("re_count", 64'(n_re), 64'(exp_re));
        chk("we_count", 64'(n_we), 64'(exp_we));
        chk("ex_count", 64'(n_ex), 64'(exp_ex));
        chk("ret_count", 64'(n_ret), 64'(exp_ret));
        chk("strobe_rules", 64'(viol), 64'd0);
        if (is_csr)  chk("re_num", 64'(re_num), 64'(csr));
        if (is_mret) chk("mret_num", 64'(re_num), 64'h341);
        if (is_trap) begin
            chk("epc", ex_epc, pc);
            chk("ecode", ex_code, (op == 4'd8) ? 64'd11 : 64'd3);
        end
        if (!is_mret) chk("rd_data", rsp_rd_data, exp_rd);
        chk("redirect", 64'(rsp_redirect), 64'(exp_redir));
        if (exp_redir) chk("target", rsp_target, exp_tgt);
        chk("illegal", 64'(rsp_illegal), 64'(exp_ill));

        s_rd = rsp_rd_data; s_tgt = rsp_target; s_redir = rsp_redirect; s_ill = rsp_illegal;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (rsp_rd_data !== s_rd || rsp_target !== s_tgt || rsp_redirect !== s_redir ||
                rsp_illegal !== s_ill || rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                csr_re || csr_we || ex || ex_ret) hold_bad++;
        end
        if (hold > 0) chk("hold_stable", 64'(hold_bad), 64'd0);

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("ready_back", 64'(req_ready), 64'd1);

        if (is_csr) begin
            ref_csr[csr] = new_v;
            chk("csr_state", slv_mem[csr], new_v);
        end else if (is_trap) begin
            ref_csr[12'h341] = pc;
            ref_csr[12'h342] = (op == 4'd8) ? 64'd11 : 64'd3;
            chk("mepc_state", slv_mem[12'h341], pc);
        end
    endtask

    initial begin
        logic [63:0] m, w;
        logic [3:0]  ill_tbl [6];
        logic [11:0] csr_tbl [4];
        int          sel;
        logic        saw_we;

        ill_tbl[0] = 4'd6;  ill_tbl[1] = 4'd7;  ill_tbl[2] = 4'd11;
        ill_tbl[3] = 4'd12; ill_tbl[4] = 4'd14; ill_tbl[5] = 4'd15;
        csr_tbl[0] = 12'h300; csr_tbl[1] = 12'h305; csr_tbl[2] = 12'h340; csr_tbl[3] = 12'h341;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_strobes", 64'({csr_re, csr_we, ex, ex_ret, rsp_valid}), 64'd0);
        chk("rst_rsp", rsp_rd_data | rsp_target | 64'({rsp_redirect, rsp_illegal}), 64'd0);
        #2 rst_n = 1'b1;
        slv_clr = 1'b0;
        @(posedge clk); #1;

        // CSRRW mtvec
        do_op(4'd0, 12'h305, 64'h8000_0100, 5'd1, '0, 0, m, w);
        chk("rw_wmask", m, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rw_wvalue", w, 64'h8000_0100);

        // Load mstatus, then CSRRS with rs1_idx=0 (read only)
        do_op(4'd0, 12'h300, 64'h0000_000a_0000_1800, 5'd2, '0, 0, m, w);
        do_op(4'd1, 12'h300, 64'hFFFF, 5'd0, '0, 1, m, w);

        // CSRRCI on mepc, then read back
        do_op(4'd0, 12'h341, 64'hF, 5'd3, '0, 0, m, w);
        do_op(4'd5, 12'h341, '0, 5'b00011, '0, 0, m, w);
        chk("rci_wmask", m, 64'h3);
        chk("rci_wvalue", w, 64'h0);
        do_op(4'd1, 12'h341, '0, 5'd0, '0, 0, m, w);

        // ECALL with 5 cycles of backpressure, then MRET
        do_op(4'd8, 12'h000, '0, 5'd0, 64'h8000_0040, 5, m, w);
        do_op(4'd10, 12'h000, '0, 5'd0, '0, 0, m, w);

        // Async reset while in WRITE
        req_op = 4'd0; req_csr = 12'h340; req_rs1_val = 64'h1234; req_rs1_idx = 5'd1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (csr_we) begin saw_we = 1'b1; break; end
        end
        chk("reached_write", 64'(saw_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_drop", 64'(csr_we), 64'd0);
        chk("rst_idle", 64'(req_ready), 64'd1);
        chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("aborted_write", slv_mem[12'h340], ref_get(12'h340));
        do_op(4'd15, 12'h340, 64'h55, 5'd7, '0, 0, m, w);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 11));
            if (sel <= 5)       req_op = 4'(sel);
            else if (sel == 6)  req_op = 4'd8;
            else if (sel == 7)  req_op = 4'd9;
            else if (sel <= 9)  req_op = 4'd10;
            else                req_op = ill_tbl[$urandom_range(0, 5)];
            do_op(req_op, csr_tbl[$urandom_range(0, 3)], {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                  {$urandom, $urandom} & ~64'd3, int'($urandom_range(0, 3)), m, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name:
csr_access_ctrl

Overview:
- Initiator side of the machine-mode CSR register file interface.
- Accepts one decoded CSR/system instruction at a time from the execute stage over a valid/ready handshake.
- Sequences the register file's read, write, exception and return strobes, then returns rd data or a PC redirect to the pipeline.
- One instruction in flight; sits between EXU and the CSR file.

Parameters:
- XLEN, 64, data width of CSR values, operands and PCs.
- ECODE_ECALL, 11, mcause code driven for ECALL (M-mode).
- ECODE_EBREAK, 3, mcause code driven for EBREAK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 CSRRWI, 4 CSRRSI, 5 CSRRCI, 8 ECALL, 9 EBREAK, 10 MRET; any other value is illegal.
- req_csr  in  12  CSR address.
- req_rs1_val  in  XLEN  rs1 operand.
- req_rs1_idx  in  5  rs1 index, or zimm for the I-forms.
- req_pc  in  XLEN  PC of the instruction.
- csr_re  out  1  read strobe.
- csr_num  out  12  CSR address.
- csr_rvalue  in  XLEN  read data.
- csr_we  out  1  write strobe.
- csr_wmask  out  XLEN  bit write mask.
- csr_wvalue  out  XLEN  write data.
- ex  out  1  exception strobe.
- ex_ret  out  1  mret strobe.
- epc  out  XLEN  exception PC.
- ecode  out  63  exception cause.
- ex_entry  in  XLEN  trap vector target.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rd_data  out  XLEN  old CSR value for rd.
- rsp_redirect  out  1  PC redirect required.
- rsp_target  out  XLEN  redirect PC.
- rsp_illegal  out  1  unsupported req_op.

Behaviour:
- States: IDLE, READ, WRITE, TRAP, ENTRY, RET, RESP.
- Request capture: a request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge.
- Output encoding: all CSR-side outputs are decoded from the state register and the latched request only; there is no combinational path from req_*.
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - Every output is 0, except req_ready = 1.
  - Response registers are cleared.
  - Reset during any state aborts the operation; no strobe is asserted after reset.

CSR ops (0-5):
- IDLE→READ.
- READ: csr_re = 1, csr_num = latched csr; csr_rvalue is captured into rsp_rd_data.
  - Next state is WRITE, or RESP if the write is suppressed.
- src = rs1_val for ops 0-2; src = zero-extended 5-bit req_rs1_idx for ops 3-5.
- WRITE: csr_we = 1, csr_num held.
  - RW: wmask = all ones, wvalue = src.
  - RS: wmask = src, wvalue = all ones.
  - RC: wmask = src, wvalue = 0.
  - Next state is RESP.
- Write suppression: RS/RC/RSI/RCI with req_rs1_idx == 0 skip WRITE. RW/RWI always write.
- csr_wmask and csr_wvalue are 0 whenever csr_we = 0.
- rsp_redirect = 0 for CSR ops.

ECALL/EBREAK:
- IDLE→TRAP.
- TRAP: ex = 1 for exactly one cycle, epc = latched pc, ecode = ECODE_*.
- Next state is ENTRY. The CSR file updates mepc and mcause at the end of TRAP.
- ENTRY: ex_entry is captured into rsp_target, rsp_redirect = 1. Next state is RESP.

MRET:
- IDLE→RET.
- RET: ex_ret = 1 and csr_re = 1 with csr_num = 12'h341. csr_rvalue (mepc) is captured into rsp_target, rsp_redirect = 1.
- Next state is RESP.

Illegal op:
- IDLE→RESP with rsp_illegal = 1.
- No CSR strobe is asserted.
- rsp_rd_data = 0, rsp_redirect = 0.

RESP:
- rsp_valid = 1; all rsp_* fields are stable until rsp_ready.
- The handshake completes on the edge where rsp_valid && rsp_ready; the next state is IDLE.
- rsp_valid drops the following cycle. There is no IDLE bypass, so back-to-back requests are spaced by at least one IDLE cycle.

Latency, accept edge to rsp_valid:
- CSR op with write: 3 cycles. CSR op with write suppressed: 2 cycles.
- ECALL/EBREAK: 3 cycles.
- MRET: 2 cycles.
- Illegal: 1 cycle.

Strobe exclusivity: at most one of csr_we, ex, ex_ret is high in any cycle. Strobes never repeat while the controller is stalled in RESP.

Test Plan:
- CSRRW, csr = 0x305, rs1_val = 0x8000_0100 (mtvec initially 0) -> csr_re for 1 cycle; csr_we next cycle with wmask = all ones, wvalue = 0x8000_0100; rsp_rd_data = 0; rsp_valid 3 cycles after accept.
- CSRRS, csr = 0x300, rs1_idx = 0 -> only csr_re is asserted, no csr_we; rsp_rd_data = 0xa00001800; rsp_valid 2 cycles after accept.
- CSRRCI, csr = 0x341, zimm = 5'b00011, mepc = 0xF -> csr_we with wmask = 0x3, wvalue = 0; a subsequent CSRRS of mepc with rs1_idx = 0 reads 0xC.
- ECALL, pc = 0x8000_0040, mtvec = 0x8000_0100 (mode 0) -> one ex pulse with epc = 0x8000_0040, ecode = 11; rsp_redirect = 1, rsp_target = 0x8000_0100; a following MRET gives rsp_target = 0x8000_0040 with a single ex_ret pulse.
- Backpressure: hold rsp_ready = 0 for 5 cycles after ECALL -> rsp_* stable; ex pulses only once; req_ready stays 0 until the edge after rsp_ready.
- Reset asserted asynchronously while in WRITE, then req_op = 15 after reset -> csr_we drops immediately and state is IDLE; the op-15 request gets rsp_illegal = 1 with no CSR strobe.
